// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/control unit.
package pipe_ctrl_pkg;

    // Default number of cycles E is held for a div/divu, start cycle included.
    localparam int DIV_CYCLES_DEF = 33;

    // Width of the divide-wait down-counter (covers DIV_CYCLES up to 63).
    localparam int DIV_CNT_W = 6;

endpackage : pipe_ctrl_pkg

// File: rtl/div_wait_ctr.sv
// Divide-wait counter: holds E for DIV_CYCLES cycles after a qualified start,
// then raises a done latch that keeps a still-frozen divide from restarting.
module div_wait_ctr
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic start_i,    // divide request already qualified by done/abort
    input  logic release_i,  // E advances this cycle (stallE low)
    input  logic abort_i,    // exception in M kills any divide wait
    output logic busy_o,
    output logic done_o
);

    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);
    localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);
    localparam logic [DIV_CNT_W-1:0] CNT_ZERO = '0;

    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 idle;
    logic                 start_go;

    assign idle     = (cnt_q == CNT_ZERO);
    assign start_go = start_i & idle & ~abort_i;
    assign busy_o   = ~idle | start_go;
    assign done_o   = done_q;

    // Next-state: abort beats everything, then load on start, else count down.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (abort_i) begin
            cnt_d  = CNT_ZERO;
            done_d = 1'b0;
        end else begin
            if (start_go) begin
                cnt_d = CNT_LOAD;
            end else if (!idle) begin
                cnt_d = cnt_q - CNT_ONE;
            end
            // Latch completion on the 1->0 step; drop it once E moves on.
            if (cnt_q == CNT_ONE) begin
                done_d = 1'b1;
            end else if (release_i) begin
                done_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= CNT_ZERO;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule : div_wait_ctr

// File: rtl/pipe_ctrl.sv
// Hazard and control unit for the five-stage core: derives per-stage stall and
// flush controls from cache stalls, load-use, divide wait and exceptions.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,              // asynchronous, active-low
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       mem_to_regE,
    input  logic [4:0] writeregE,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       use_rsD,
    input  logic       use_rtD,
    input  logic       branch_mispredE,
    input  logic       div_startE,
    input  logic       exceptM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       div_busy,
    output logic       longest_stall,
    output logic       redirect_pending
);

    logic freeze;
    logic lu;
    logic div_done;
    logic div_start_req;
    logic redirect_q, redirect_d;

    assign freeze = i_stall | d_stall;

    assign lu = mem_to_regE & (writeregE != 5'd0) &
                ((use_rsD & (rsD == writeregE)) | (use_rtD & (rtD == writeregE)));

    // A divide still sitting in E after completing must not start again.
    assign div_start_req = div_startE & ~div_done & ~exceptM;

    div_wait_ctr #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_wait (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start_req),
        .release_i (~stallE),
        .abort_i   (exceptM),
        .busy_o    (div_busy),
        .done_o    (div_done)
    );

    assign stallW = freeze;
    assign stallM = freeze;
    assign stallE = freeze | div_busy;
    assign stallD = stallE | lu;
    assign stallF = stallD;

    assign flushW = exceptM;
    assign flushM = exceptM | (div_busy & ~freeze);
    assign flushE = exceptM | (lu & ~stallE);
    assign flushD = exceptM | (branch_mispredE & ~stallE);

    assign longest_stall = freeze | div_busy;

    // Redirect owed to fetch: set while fetch is stalled at exception time,
    // held until fetch is free for one cycle.
    always_comb begin
        redirect_d = redirect_q;
        if (exceptM & i_stall) begin
            redirect_d = 1'b1;
        end else if (!i_stall) begin
            redirect_d = 1'b0;
        end
    end

    assign redirect_pending = redirect_q | (exceptM & i_stall);

    // Sticky redirect flag with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= redirect_d;
        end
    end

endmodule : pipe_ctrl
